// File: rtl/pr_ar_arbiter.sv
// Shares one downstream AXI read port between demand and prefetch requesters; records issue order
// and steers R bursts back. Define PR_ARB_PERF_CNT_EN to build the 32-bit grant counters.
module pr_ar_arbiter #(
    parameter int ADDR_BITS            = 64,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int BLOCK_DATA_SIZE_BITS = 512,
    parameter int LOG_ORDER_DEPTH      = 4,
    parameter int STARVE_WIDTH         = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [STARVE_WIDTH-1:0]         starveLimit,

    input  logic                            d_ar_valid,
    output logic                            d_ar_ready,
    input  logic [ADDR_BITS-1:0]            d_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0]      d_ar_len,
    input  logic [TID_WIDTH-1:0]            d_ar_id,

    input  logic                            p_ar_valid,
    output logic                            p_ar_ready,
    input  logic [ADDR_BITS-1:0]            p_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0]      p_ar_len,
    input  logic [TID_WIDTH-1:0]            p_ar_id,

    output logic                            m_ar_valid,
    input  logic                            m_ar_ready,
    output logic [ADDR_BITS-1:0]            m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]      m_ar_len,
    output logic [TID_WIDTH-1:0]            m_ar_id,

    input  logic                            m_r_valid,
    output logic                            m_r_ready,
    input  logic                            m_r_last,
    input  logic [BLOCK_DATA_SIZE_BITS-1:0] m_r_data,
    input  logic [TID_WIDTH-1:0]            m_r_id,

    output logic                            d_r_valid,
    input  logic                            d_r_ready,
    output logic                            d_r_last,
    output logic [BLOCK_DATA_SIZE_BITS-1:0] d_r_data,
    output logic [TID_WIDTH-1:0]            d_r_id,

    output logic                            p_r_valid,
    input  logic                            p_r_ready,
    output logic                            p_r_last,
    output logic [BLOCK_DATA_SIZE_BITS-1:0] p_r_data,

    output logic [LOG_ORDER_DEPTH:0]        outstandingDemand,
    output logic [LOG_ORDER_DEPTH:0]        outstandingPrefetch,
    output logic                            orderFull,
    output logic                            flushDone,
    output logic                            protocolErr,

    output logic [31:0]                     perfDemandGrants,
    output logic [31:0]                     perfPrefetchGrants,
    output logic [31:0]                     perfForcedGrants
);

    localparam int DEPTH = 1 << LOG_ORDER_DEPTH;
    localparam int CNT_W = LOG_ORDER_DEPTH + 1;

    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_HOLD = 1'b1;
    localparam logic SRC_DEMAND   = 1'b0;
    localparam logic SRC_PREFETCH = 1'b1;

    localparam logic [CNT_W-1:0]           CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]           CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [LOG_ORDER_DEPTH-1:0] PTR_ONE    = LOG_ORDER_DEPTH'(1);
    localparam logic [STARVE_WIDTH-1:0]    STARVE_ONE = STARVE_WIDTH'(1);

    logic [0:0]                 ar_state;
    logic                       hold_src;
    logic [STARVE_WIDTH-1:0]    starve_cnt;
    logic [LOG_ORDER_DEPTH-1:0] wr_ptr;
    logic [LOG_ORDER_DEPTH-1:0] rd_ptr;
    logic [CNT_W-1:0]           ord_cnt;
    logic [CNT_W-1:0]           dem_cnt;
    logic [CNT_W-1:0]           pf_cnt;
    logic [CNT_W-1:0]           ord_cnt_nxt;
    logic [CNT_W-1:0]           dem_cnt_nxt;
    logic [CNT_W-1:0]           pf_cnt_nxt;
    logic                       ord_src [DEPTH];
    logic [TID_WIDTH-1:0]       ord_id  [DEPTH];
    logic                       err_q;

    logic                 d_cand;
    logic                 p_cand;
    logic                 starving;
    logic                 can_grant;
    logic                 grant_d;
    logic                 grant_p;
    logic                 push;
    logic                 fifo_empty;
    logic                 head_src;
    logic [TID_WIDTH-1:0] head_id;
    logic                 pop;
    logic                 pop_d;
    logic                 pop_p;
    logic                 r_err;

    // AR arbitration: demand wins unless the starvation limit forces a prefetch grant.
    assign fifo_empty = (ord_cnt == '0);
    assign orderFull  = (ord_cnt == CNT_FULL);
    assign d_cand     = d_ar_valid;
    assign p_cand     = p_ar_valid && !flush;
    assign starving   = (starveLimit != '0) && (starve_cnt >= starveLimit);
    assign can_grant  = (ar_state == AR_IDLE) && !orderFull;
    assign grant_p    = can_grant && p_cand && (starving || !d_cand);
    assign grant_d    = can_grant && d_cand && !grant_p;
    assign push       = grant_d || grant_p;
    assign d_ar_ready = grant_d;
    assign p_ar_ready = grant_p;
    assign m_ar_valid = (ar_state == AR_HOLD);

    assign head_src  = ord_src[rd_ptr];
    assign head_id   = ord_id[rd_ptr];
    assign d_r_valid = m_r_valid && !fifo_empty && (head_src == SRC_DEMAND);
    assign p_r_valid = m_r_valid && !fifo_empty && (head_src == SRC_PREFETCH);
    assign m_r_ready = !fifo_empty && ((head_src == SRC_PREFETCH) ? p_r_ready : d_r_ready);
    assign pop       = m_r_valid && m_r_ready && m_r_last;
    assign pop_d     = pop && (head_src == SRC_DEMAND);
    assign pop_p     = pop && (head_src == SRC_PREFETCH);
    assign r_err     = m_r_valid && (fifo_empty || (m_r_id != head_id));

    assign d_r_last = m_r_last;
    assign d_r_data = m_r_data;
    assign d_r_id   = m_r_id;
    assign p_r_last = m_r_last;
    assign p_r_data = m_r_data;

    assign outstandingDemand   = dem_cnt;
    assign outstandingPrefetch = pf_cnt;
    assign protocolErr         = err_q;
    assign flushDone = flush && (pf_cnt == '0) &&
                       !((ar_state == AR_HOLD) && (hold_src == SRC_PREFETCH));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ord_cnt_nxt = ord_cnt;
        dem_cnt_nxt = dem_cnt;
        pf_cnt_nxt  = pf_cnt;
        if (push && !pop)
            ord_cnt_nxt = ord_cnt + CNT_ONE;
        else if (pop && !push)
            ord_cnt_nxt = ord_cnt - CNT_ONE;
        if (grant_d && !pop_d)
            dem_cnt_nxt = dem_cnt + CNT_ONE;
        else if (pop_d && !grant_d)
            dem_cnt_nxt = dem_cnt - CNT_ONE;
        if (grant_p && !pop_p)
            pf_cnt_nxt = pf_cnt + CNT_ONE;
        else if (pop_p && !grant_p)
            pf_cnt_nxt = pf_cnt - CNT_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state   <= AR_IDLE;
            hold_src   <= SRC_DEMAND;
            m_ar_addr  <= '0;
            m_ar_len   <= '0;
            m_ar_id    <= '0;
            starve_cnt <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ord_cnt    <= '0;
            dem_cnt    <= '0;
            pf_cnt     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (ar_state == AR_IDLE) begin
                if (push) begin
                    ar_state  <= AR_HOLD;
                    hold_src  <= grant_p;
                    m_ar_addr <= grant_p ? p_ar_addr : d_ar_addr;
                    m_ar_len  <= grant_p ? p_ar_len  : d_ar_len;
                    m_ar_id   <= grant_p ? p_ar_id   : d_ar_id;
                end
            end else if (m_ar_ready) begin
                ar_state <= AR_IDLE;
            end

            if (grant_p)
                starve_cnt <= '0;
            else if (grant_d && p_cand && (starve_cnt != '1))
                starve_cnt <= starve_cnt + STARVE_ONE;

            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            ord_cnt <= ord_cnt_nxt;
            dem_cnt <= dem_cnt_nxt;
            pf_cnt  <= pf_cnt_nxt;

            if (r_err)
                err_q <= 1'b1;
        end
    end

    // NOTE: order storage is not reset; ord_cnt gates every use, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push) begin
            ord_src[wr_ptr] <= grant_p;
            ord_id[wr_ptr]  <= grant_p ? p_ar_id : d_ar_id;
        end
    end

`ifdef PR_ARB_PERF_CNT_EN
    // A forced grant is a prefetch win over a waiting demand request.
    always_ff @(posedge clk) begin
        if (reset) begin
            perfDemandGrants   <= '0;
            perfPrefetchGrants <= '0;
            perfForcedGrants   <= '0;
        end else begin
            if (grant_d)
                perfDemandGrants <= perfDemandGrants + 32'd1;
            if (grant_p)
                perfPrefetchGrants <= perfPrefetchGrants + 32'd1;
            if (grant_p && starving && d_cand)
                perfForcedGrants <= perfForcedGrants + 32'd1;
        end
    end
`else
    assign perfDemandGrants   = '0;
    assign perfPrefetchGrants = '0;
    assign perfForcedGrants   = '0;
`endif

endmodule

// File: tb/tb_pr_ar_arbiter.sv
// Self-checking bench for pr_ar_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_pr_ar_arbiter;
    localparam int AW   = 64;
    localparam int LW   = 8;
    localparam int IW   = 8;
    localparam int DW   = 512;
    localparam int LOGD = 4;
    localparam int SW   = 4;

    logic clk = 1'b0;
    logic reset, flush;
    logic [SW-1:0] starveLimit;
    logic d_ar_valid, d_ar_ready, p_ar_valid, p_ar_ready, m_ar_valid, m_ar_ready;
    logic [AW-1:0] d_ar_addr, p_ar_addr, m_ar_addr;
    logic [LW-1:0] d_ar_len, p_ar_len, m_ar_len;
    logic [IW-1:0] d_ar_id, p_ar_id, m_ar_id, m_r_id, d_r_id;
    logic m_r_valid, m_r_ready, m_r_last, d_r_valid, d_r_ready, d_r_last;
    logic p_r_valid, p_r_ready, p_r_last;
    logic [DW-1:0] m_r_data, d_r_data, p_r_data;
    logic [LOGD:0] outstandingDemand, outstandingPrefetch;
    logic orderFull, flushDone, protocolErr;
    logic [31:0] perfDemandGrants, perfPrefetchGrants, perfForcedGrants;

    always #5 clk = ~clk;

    pr_ar_arbiter dut (
        .clk(clk), .reset(reset), .flush(flush), .starveLimit(starveLimit),
        .d_ar_valid(d_ar_valid), .d_ar_ready(d_ar_ready), .d_ar_addr(d_ar_addr),
        .d_ar_len(d_ar_len), .d_ar_id(d_ar_id),
        .p_ar_valid(p_ar_valid), .p_ar_ready(p_ar_ready), .p_ar_addr(p_ar_addr),
        .p_ar_len(p_ar_len), .p_ar_id(p_ar_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
        .m_r_data(m_r_data), .m_r_id(m_r_id),
        .d_r_valid(d_r_valid), .d_r_ready(d_r_ready), .d_r_last(d_r_last),
        .d_r_data(d_r_data), .d_r_id(d_r_id),
        .p_r_valid(p_r_valid), .p_r_ready(p_r_ready), .p_r_last(p_r_last),
        .p_r_data(p_r_data),
        .outstandingDemand(outstandingDemand), .outstandingPrefetch(outstandingPrefetch),
        .orderFull(orderFull), .flushDone(flushDone), .protocolErr(protocolErr),
        .perfDemandGrants(perfDemandGrants), .perfPrefetchGrants(perfPrefetchGrants),
        .perfForcedGrants(perfForcedGrants)
    );

    typedef struct packed {
        logic          src;
        logic [IW-1:0] id;
    } ord_t;

    typedef struct {
        logic          d_v;
        logic          p_v;
        logic          fl;
        logic [SW-1:0] lim;
        logic          exp_dr;
        logic          exp_pr;
        logic          exp_fd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle_inputs();
        flush = 0; starveLimit = '0;
        d_ar_valid = 0; d_ar_addr = '0; d_ar_len = '0; d_ar_id = '0;
        p_ar_valid = 0; p_ar_addr = '0; p_ar_len = '0; p_ar_id = '0;
        m_ar_ready = 0; m_r_valid = 0; m_r_last = 0; m_r_data = '0; m_r_id = '0;
        d_r_ready = 0; p_r_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // One AR from the given source through grant and master handshake (m_ar_ready must be 1).
    task automatic issue(input logic src, input logic [IW-1:0] id);
        if (src) begin p_ar_valid = 1; p_ar_id = id; end
        else     begin d_ar_valid = 1; d_ar_id = id; end
        #1;
        check("issue_ready", src ? p_ar_ready : d_ar_ready, 1'b1);
        tick();
        d_ar_valid = 0; p_ar_valid = 0;
        tick();
    endtask

    task automatic run_random(input int cycles, input bit allow_err);
        ord_t q[$];
        ord_t hold_ord;
        logic [AW-1:0] hold_addr;
        logic [LW-1:0] hold_len;
        bit   holding = 0;
        int   starve = 0;
        bit   err = 0;
        int   n_gd = 0, n_gp = 0, n_forced = 0;
        for (int c = 0; c < cycles; c++) begin
            bit full, starving, pc, gd, gp, ne, hsrc, exp_mrr;
            logic [IW-1:0] hid;
            int nd, np;
            d_ar_valid = 1'($urandom % 2);
            p_ar_valid = 1'($urandom % 2);
            flush      = ($urandom % 8) == 0;
            d_ar_addr  = {$urandom, $urandom}; d_ar_len = LW'($urandom); d_ar_id = IW'($urandom);
            p_ar_addr  = {$urandom, $urandom}; p_ar_len = LW'($urandom); p_ar_id = IW'($urandom);
            m_ar_ready = 1'($urandom % 2);
            d_r_ready  = ($urandom % 4) != 0;
            p_r_ready  = ($urandom % 4) != 0;
            m_r_last   = 1'($urandom % 2);
            m_r_data   = rand_data();
            if (q.size() > 0) begin
                m_r_valid = ($urandom % 5) < 2;
                m_r_id    = q[0].id;
                if (allow_err && ($urandom % 25) == 0) m_r_id = IW'($urandom);
            end else begin
                m_r_valid = allow_err && (($urandom % 10) == 0);
                m_r_id    = IW'($urandom);
            end
            #1;
            full     = (q.size() == 16);
            pc       = p_ar_valid && !flush;
            starving = (starveLimit != 0) && (starve >= int'(starveLimit));
            gp = !holding && !full && pc && (starving || !d_ar_valid);
            gd = !holding && !full && d_ar_valid && !gp;
            ne   = q.size() > 0;
            hsrc = ne ? q[0].src : 1'b0;
            hid  = ne ? q[0].id : '0;
            exp_mrr = ne && (hsrc ? p_r_ready : d_r_ready);
            nd = 0; np = 0;
            foreach (q[i]) if (q[i].src) np++; else nd++;

            check("rnd_d_ar_ready", d_ar_ready, gd);
            check("rnd_p_ar_ready", p_ar_ready, gp);
            check("rnd_m_ar_valid", m_ar_valid, holding);
            if (holding) begin
                check("rnd_m_ar_addr", m_ar_addr, hold_addr);
                check("rnd_m_ar_len", m_ar_len, hold_len);
                check("rnd_m_ar_id", m_ar_id, hold_ord.id);
            end
            check("rnd_m_r_ready", m_r_ready, exp_mrr);
            check("rnd_d_r_valid", d_r_valid, m_r_valid && ne && !hsrc);
            check("rnd_p_r_valid", p_r_valid, m_r_valid && ne && hsrc);
            if (m_r_valid && ne && !hsrc) begin
                check("rnd_d_r_data", d_r_data, m_r_data);
                check("rnd_d_r_id", d_r_id, m_r_id);
                check("rnd_d_r_last", d_r_last, m_r_last);
            end
            if (m_r_valid && ne && hsrc) check("rnd_p_r_data", p_r_data, m_r_data);
            check("rnd_out_demand", outstandingDemand, nd);
            check("rnd_out_prefetch", outstandingPrefetch, np);
            check("rnd_order_full", orderFull, full);
            check("rnd_flush_done", flushDone,
                  flush && (np == 0) && !(holding && hold_ord.src));
            check("rnd_protocol_err", protocolErr, err);

            if (m_r_valid && (!ne || m_r_id != hid)) err = 1;
            if (m_r_valid && exp_mrr && m_r_last) void'(q.pop_front());
            if (holding && m_ar_ready) holding = 0;
            if (gd || gp) begin
                holding      = 1;
                hold_ord.src = gp;
                hold_ord.id  = gp ? p_ar_id : d_ar_id;
                hold_addr    = gp ? p_ar_addr : d_ar_addr;
                hold_len     = gp ? p_ar_len : d_ar_len;
                q.push_back(hold_ord);
            end
            if (gp) begin
                n_gp++;
                if (starving && d_ar_valid) n_forced++;
                starve = 0;
            end else if (gd) begin
                n_gd++;
                if (pc && starve < 15) starve++;
            end
            tick();
        end
`ifdef PR_ARB_PERF_CNT_EN
        check("rnd_perf_demand", perfDemandGrants, n_gd);
        check("rnd_perf_prefetch", perfPrefetchGrants, n_gp);
        check("rnd_perf_forced", perfForcedGrants, n_forced);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic [7:0] pat;
        logic [2:0] burst_src;
        int exp_d[3];
        int exp_p[3];

        reset = 0;
        do_reset();

        // Reset state
        check("rst_m_ar_valid", m_ar_valid, 1'b0);
        check("rst_m_ar_addr", m_ar_addr, '0);
        check("rst_m_ar_len", m_ar_len, '0);
        check("rst_m_ar_id", m_ar_id, '0);
        check("rst_out_demand", outstandingDemand, '0);
        check("rst_out_prefetch", outstandingPrefetch, '0);
        check("rst_order_full", orderFull, 1'b0);
        check("rst_protocol_err", protocolErr, 1'b0);
        check("rst_perf_demand", perfDemandGrants, '0);
        check("rst_perf_forced", perfForcedGrants, '0);

        // Idle-state grant table (starvation counter is 0 after reset)
        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            d_ar_valid = vecs[i].d_v; p_ar_valid = vecs[i].p_v;
            flush = vecs[i].fl; starveLimit = vecs[i].lim;
            #1;
            check($sformatf("vec%0d_d_ar_ready", i), d_ar_ready, vecs[i].exp_dr);
            check($sformatf("vec%0d_p_ar_ready", i), p_ar_ready, vecs[i].exp_pr);
            check($sformatf("vec%0d_flush_done", i), flushDone, vecs[i].exp_fd);
            idle_inputs();
            tick();
        end

        // Both valid, no forcing: demand only, one AR per two cycles
        do_reset();
        d_ar_valid = 1; p_ar_valid = 1; m_ar_ready = 1; d_ar_id = 8'h11; p_ar_id = 8'h22;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("nf_d_ar_ready", d_ar_ready, (i % 2) == 0);
            check("nf_p_ar_ready", p_ar_ready, 1'b0);
            check("nf_m_ar_valid", m_ar_valid, (i % 2) == 1);
            if (i % 2 == 1) check("nf_m_ar_id", m_ar_id, 8'h11);
            tick();
        end
        check("nf_out_demand", outstandingDemand, 4);

        // Starvation limit 3: D,D,D,P,D,D,D,P
        do_reset();
        starveLimit = 3;
        d_ar_valid = 1; p_ar_valid = 1; m_ar_ready = 1; d_ar_id = 8'h11; p_ar_id = 8'h22;
        pat = 8'b1000_1000;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (i % 2 == 0) begin
                check($sformatf("sv_grant%0d_d", i / 2), d_ar_ready, !pat[i/2]);
                check($sformatf("sv_grant%0d_p", i / 2), p_ar_ready, pat[i/2]);
            end else begin
                check($sformatf("sv_m_ar_id%0d", i / 2), m_ar_id, pat[i/2] ? 8'h22 : 8'h11);
            end
            tick();
        end
        check("sv_out_demand", outstandingDemand, 6);
        check("sv_out_prefetch", outstandingPrefetch, 2);
`ifdef PR_ARB_PERF_CNT_EN
        check("sv_perf_forced", perfForcedGrants, 2);
        check("sv_perf_demand", perfDemandGrants, 6);
        check("sv_perf_prefetch", perfPrefetchGrants, 2);
`else
        check("sv_perf_forced_off", perfForcedGrants, '0);
        check("sv_perf_prefetch_off", perfPrefetchGrants, '0);
`endif

        // Steering: D(5), P(5), D(5), two beats per burst
        do_reset();
        m_ar_ready = 1;
        issue(1'b0, 8'd5);
        issue(1'b1, 8'd5);
        issue(1'b0, 8'd5);
        d_ar_valid = 0; p_ar_valid = 0;
        burst_src = 3'b010;
        exp_d = '{2, 1, 1};
        exp_p = '{1, 1, 0};
        d_r_ready = 1; p_r_ready = 1;
        for (int b = 0; b < 3; b++) begin
            for (int beat = 0; beat < 2; beat++) begin
                m_r_valid = 1; m_r_last = (beat == 1); m_r_id = 8'd5; m_r_data = rand_data();
                #1;
                if (beat == 0) begin
                    check($sformatf("st_out_demand_b%0d", b), outstandingDemand, exp_d[b]);
                    check($sformatf("st_out_prefetch_b%0d", b), outstandingPrefetch, exp_p[b]);
                end
                check($sformatf("st_d_r_valid_b%0d", b), d_r_valid, !burst_src[b]);
                check($sformatf("st_p_r_valid_b%0d", b), p_r_valid, burst_src[b]);
                check("st_m_r_ready", m_r_ready, 1'b1);
                if (burst_src[b]) check("st_p_r_data", p_r_data, m_r_data);
                else              check("st_d_r_data", d_r_data, m_r_data);
                tick();
            end
        end
        m_r_valid = 0;
        #1;
        check("st_out_demand_end", outstandingDemand, 0);
        check("st_out_prefetch_end", outstandingPrefetch, 0);
        check("st_protocol_err", protocolErr, 1'b0);

        // Fill the order FIFO, then pop one entry and refill
        do_reset();
        m_ar_ready = 1; d_ar_valid = 1;
        for (int i = 0; i < 32; i++) begin
            d_ar_id = IW'(i / 2);
            tick();
        end
        p_ar_valid = 1;
        #1;
        check("full_order_full", orderFull, 1'b1);
        check("full_out_demand", outstandingDemand, 16);
        check("full_d_ar_ready", d_ar_ready, 1'b0);
        check("full_p_ar_ready", p_ar_ready, 1'b0);
        tick();
        check("full_hold_d_ar_ready", d_ar_ready, 1'b0);
        m_r_valid = 1; m_r_last = 1; m_r_id = 8'd0; d_r_ready = 1;
        #1;
        check("full_pop_m_r_ready", m_r_ready, 1'b1);
        check("full_pop_d_ar_ready", d_ar_ready, 1'b0);
        tick();
        m_r_valid = 0; p_ar_valid = 0; d_ar_id = 8'hAA;
        #1;
        check("full_after_pop_full", orderFull, 1'b0);
        check("full_after_pop_count", outstandingDemand, 15);
        check("full_after_pop_grant", d_ar_ready, 1'b1);
        tick();
        check("full_refill_count", outstandingDemand, 16);
        check("full_refill_full", orderFull, 1'b1);
        check("full_refill_m_ar_id", m_ar_id, 8'hAA);
        check("full_protocol_err", protocolErr, 1'b0);

        // Flush with two prefetch bursts outstanding, one still in AR hold
        do_reset();
        m_ar_ready = 1;
        issue(1'b1, 8'd7);
        m_ar_ready = 0; p_ar_valid = 1; p_ar_id = 8'd8;
        tick();
        flush = 1;
        #1;
        check("fl_hold_m_ar_valid", m_ar_valid, 1'b1);
        check("fl_hold_m_ar_id", m_ar_id, 8'd8);
        check("fl_hold_p_ar_ready", p_ar_ready, 1'b0);
        check("fl_hold_flush_done", flushDone, 1'b0);
        tick();
        m_ar_ready = 1;
        tick();
        check("fl_idle_p_ar_ready", p_ar_ready, 1'b0);
        check("fl_idle_m_ar_valid", m_ar_valid, 1'b0);
        check("fl_out_prefetch", outstandingPrefetch, 2);
        p_r_ready = 1; m_r_valid = 1; m_r_last = 1; m_r_id = 8'd7;
        #1;
        check("fl_beat1_p_r_valid", p_r_valid, 1'b1);
        check("fl_beat1_flush_done", flushDone, 1'b0);
        tick();
        m_r_id = 8'd8;
        #1;
        check("fl_beat2_flush_done", flushDone, 1'b0);
        check("fl_beat2_p_ar_ready", p_ar_ready, 1'b0);
        tick();
        m_r_valid = 0;
        #1;
        check("fl_done", flushDone, 1'b1);
        check("fl_done_p_ar_ready", p_ar_ready, 1'b0);
        check("fl_done_out_prefetch", outstandingPrefetch, 0);
        flush = 0;
        #1;
        check("fl_release_p_ar_ready", p_ar_ready, 1'b1);
        check("fl_release_flush_done", flushDone, 1'b0);
        p_ar_valid = 0;
        tick();

        // R beat with an empty order FIFO
        do_reset();
        m_r_valid = 1; m_r_last = 1; d_r_ready = 1; p_r_ready = 1;
        #1;
        check("err_m_r_ready", m_r_ready, 1'b0);
        check("err_d_r_valid", d_r_valid, 1'b0);
        check("err_before_edge", protocolErr, 1'b0);
        tick();
        m_r_valid = 0;
        check("err_set", protocolErr, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check("err_sticky", protocolErr, 1'b1);
        do_reset();
        check("err_cleared_by_reset", protocolErr, 1'b0);

        // Randomized runs against the reference model
        do_reset();
        starveLimit = 2;
        run_random(1500, 1'b0);
        do_reset();
        starveLimit = 0;
        run_random(800, 1'b0);
        do_reset();
        starveLimit = 5;
        run_random(1200, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
